priority_drain_encoder: RTL and testbench
=========================================

PRIORITY_DRAIN_ENCODER -- requirements
Module: priority_drain_encoder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, number of request bits (legal values 2..64).
REQ-002 The block SHALL have one derived constant: CODE_W = clog2(WIDTH), the width of the code output.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in, input, WIDTH bits: the request vector, sampled only on an accepted capture.
REQ-006 The block SHALL have port sample, input, 1 bit: capture strobe.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a captured vector is being drained; sample is ignored while busy=1.
REQ-008 The block SHALL have port code, output, CODE_W bits: index of the highest set bit remaining in the captured vector.
REQ-009 The block SHALL have port z, output, 1 bit: high only when the captured vector was all zero.
REQ-010 The block SHALL have port valid, output, 1 bit: code, z and last are valid.
REQ-011 The block SHALL have port ready, input, 1 bit: the consumer accepts the current beat when valid and ready are both high at a rising edge.
REQ-012 The block SHALL have port last, output, 1 bit: the current beat is the final one of the captured vector.

Function
REQ-013 The block SHALL have two states, IDLE (busy=0, valid=0) and DRAIN (busy=1, valid=1).
REQ-014 In IDLE, sample=1 at a rising edge SHALL load in into an internal remaining-vector register and enter DRAIN; valid SHALL be high from that edge (one-cycle latency).
REQ-015 Priority SHALL be MSB-first: code is the highest set index of the remaining vector, so any in within 32..63 with WIDTH=8 yields first code 5 and z=0.
REQ-016 If the captured vector is zero, the block SHALL emit exactly one beat with code=0, z=1, last=1.
REQ-017 On a handshake with last=0, the block SHALL clear the granted bit and present the next-highest set bit on the following cycle, giving one beat per cycle under continuous ready.
REQ-018 On a handshake with last=1, the block SHALL return to IDLE, with valid and busy low on the next cycle.
REQ-019 last SHALL be high when exactly one bit remains set, or on the single zero-vector beat.
REQ-020 While valid=1 and ready=0, code, z and last SHALL hold stable.
REQ-021 code, z, last, valid and busy SHALL be registered outputs.
REQ-022 sample asserted in DRAIN, including in the same cycle as the last handshake, SHALL be ignored; a new capture is possible at the earliest on the first IDLE cycle.

Reset
REQ-023 When rst_n=0, the block SHALL immediately force state=IDLE, remaining vector=0, code=0, z=0, last=0, valid=0 and busy=0.
REQ-024 Reset asserted mid-drain SHALL abandon the remaining beats; no beat SHALL be emitted after reset release until a new capture.

Configuration
REQ-025 When macro PRIO_ENC_COUNT_EN is defined, the block SHALL add output count (CODE_W+1 bits), registered at capture, holding the population count of the captured in and stable until the next capture (reset value 0).
REQ-026 When PRIO_ENC_COUNT_EN is undefined, the count port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-027 A shared package prio_pkg SHALL hold the state enum (IDLE, DRAIN) and a clog2 helper function.
REQ-028 The design SHALL include one sub-module, prio_enc_comb (parametrised WIDTH, combinational highest-set-bit encoder with zero flag), instantiated for the capture path and for the next-remaining path.

Verification (WIDTH=8)
REQ-029 The bench SHALL check: in=8'b0010_1100, sample, ready=1 -> beats code=5,3,2 on consecutive cycles, z=0, last only on code 2, then busy=0.
REQ-030 The bench SHALL check: in=0, sample -> one beat code=0, z=1, last=1, then IDLE.
REQ-031 The bench SHALL check: in swept 32..63, each captured -> first beat code=3'b101, z=0.
REQ-032 The bench SHALL check: in=8'b1000_0001, ready=0 for 4 cycles -> code=7 held, valid=1; ready=1 -> code=0 with last=1.
REQ-033 The bench SHALL check: rst_n pulsed low during the second beat of 8'b1110_0000 -> valid=0 and busy=0 immediately, no further beats after release; sample during DRAIN with in=8'hFF -> ignored.
REQ-034 With PRIO_ENC_COUNT_EN defined, the bench SHALL check: in=8'b1011_0110 -> count=5 from the capture edge until the next capture.

Source files
------------

// File: rtl/prio_pkg.sv
// prio_pkg: shared drain FSM state type and clog2 helper for the priority drain encoder
package prio_pkg;
  typedef enum logic {IDLE, DRAIN} state_t;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction
endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational MSB-first encoder; ports vec (WIDTH) -> code (index of highest set bit, 0 if none), zero (vec is all zero)
module prio_enc_comb import prio_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int CODE_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              zero
);
  always_comb begin
    code = '0;
    for (int i = 0; i < WIDTH; i++) code = vec[i] ? CODE_W'(i) : code;
  end
  assign zero = ~|vec;
endmodule

// File: rtl/priority_drain_encoder.sv
// priority_drain_encoder: captures in on sample while idle and drains its set bits MSB-first as valid/ready beats; ports clk, rst_n (async low), in, sample, ready -> busy, valid, code, z, last, plus count (popcount at capture) when PRIO_ENC_COUNT_EN is defined
module priority_drain_encoder import prio_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int CODE_W = clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              sample,
  input  logic              ready,
  output logic              busy,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic              z,
  output logic              last
`ifdef PRIO_ENC_COUNT_EN
  ,output logic [CODE_W:0]  count
`endif
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [CODE_W-1:0] cap_code, nxt_code;
  logic cap_z, nxt_z, cap_last, nxt_last, capture, take;
  prio_enc_comb #(.WIDTH(WIDTH)) u_cap (.vec(in), .code(cap_code), .zero(cap_z));
  prio_enc_comb #(.WIDTH(WIDTH)) u_nxt (.vec(rem_nxt), .code(nxt_code), .zero(nxt_z));
  assign capture  = (state == IDLE) && sample;
  assign take     = (state == DRAIN) && ready;
  assign rem_nxt  = rem & ~(WIDTH'(1) << code);
  assign cap_last = ~|(in & ~(WIDTH'(1) << cap_code));
  assign nxt_last = ~|(rem_nxt & ~(WIDTH'(1) << nxt_code));
  assign busy     = (state == DRAIN);
  assign valid    = (state == DRAIN);
  always_comb begin
    state_nxt = state;
    state_nxt = capture ? DRAIN : (take && last) ? IDLE : state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      code  <= '0;
      z     <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rem  <= in;
        code <= cap_code;
        z    <= cap_z;
        last <= cap_last;
      end else if (take) begin
        rem  <= last ? '0 : rem_nxt;
        code <= last ? '0 : nxt_code;
        z    <= last ? 1'b0 : nxt_z;
        last <= last ? 1'b0 : nxt_last;
      end
    end
  end
`ifdef PRIO_ENC_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (capture) count <= (CODE_W+1)'($countones(in));
  end
`endif
endmodule

// File: tb/tb_priority_drain_encoder.sv
// tb_priority_drain_encoder: directed self-checking bench for priority_drain_encoder at WIDTH=8
module tb_priority_drain_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in = '0;
  logic sample = 1'b0;
  logic ready = 1'b0;
  logic busy, valid, z, last;
  logic [2:0] code;
  int checks = 0;
  int errors = 0;
`ifdef PRIO_ENC_COUNT_EN
  logic [3:0] count;
`endif
  priority_drain_encoder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sample(sample), .ready(ready),
    .busy(busy), .valid(valid), .code(code), .z(z), .last(last)
`ifdef PRIO_ENC_COUNT_EN
    ,.count(count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input string tag, input logic v, input logic [2:0] c, input logic zz, input logic l);
    chk({tag, "_valid"}, valid, v);
    chk({tag, "_busy"}, busy, v);
    chk({tag, "_code"}, code, c);
    chk({tag, "_z"}, z, zz);
    chk({tag, "_last"}, last, l);
  endtask
  task automatic drain();
    int n = 0;
    ready = 1'b1;
    while (valid && n < 20) begin
      step();
      n++;
    end
    chk("drain_done", valid, 1'b0);
  endtask
  initial begin
    #2;
    beat("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    beat("idle", 0, 0, 0, 0);
    in = 8'b0010_1100; sample = 1'b1; ready = 1'b1;
    step();
    sample = 1'b0;
    beat("b2c_0", 1, 5, 0, 0);
    step();
    beat("b2c_1", 1, 3, 0, 0);
    step();
    beat("b2c_2", 1, 2, 0, 1);
    step();
    beat("b2c_end", 0, 0, 0, 0);
    in = 8'h00; sample = 1'b1;
    step();
    sample = 1'b0;
    beat("zero_0", 1, 0, 1, 1);
    step();
    beat("zero_end", 0, 0, 0, 0);
    for (int i = 32; i < 64; i++) begin
      in = 8'(i); sample = 1'b1; ready = 1'b0;
      step();
      sample = 1'b0;
      chk("sweep_code", code, 3'b101);
      chk("sweep_z", z, 1'b0);
      drain();
    end
    in = 8'b1000_0001; sample = 1'b1; ready = 1'b0;
    step();
    sample = 1'b0;
    beat("hold_first", 1, 7, 0, 0);
    repeat (4) begin
      step();
      beat("hold", 1, 7, 0, 0);
    end
    ready = 1'b1;
    step();
    beat("hold_rel", 1, 0, 0, 1);
    step();
    beat("hold_end", 0, 0, 0, 0);
    in = 8'b1110_0000; sample = 1'b1; ready = 1'b1;
    step();
    sample = 1'b0;
    beat("rst_b0", 1, 7, 0, 0);
    step();
    beat("rst_b1", 1, 6, 0, 0);
    rst_n = 1'b0;
    #1;
    beat("rst_mid", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      beat("rst_after", 0, 0, 0, 0);
    end
    in = 8'b0000_0110; sample = 1'b1; ready = 1'b0;
    step();
    beat("ign_0", 1, 2, 0, 0);
    in = 8'hFF;
    step();
    beat("ign_hold", 1, 2, 0, 0);
    ready = 1'b1;
    step();
    beat("ign_1", 1, 1, 0, 1);
    step();
    beat("ign_lastcyc", 0, 0, 0, 0);
    step();
    sample = 1'b0;
    beat("ign_recap", 1, 7, 0, 0);
    drain();
`ifdef PRIO_ENC_COUNT_EN
    in = 8'b1011_0110; sample = 1'b1; ready = 1'b0;
    step();
    sample = 1'b0; in = 8'hFF;
    chk("count_cap", count, 4'd5);
    step();
    chk("count_hold", count, 4'd5);
    drain();
    chk("count_idle", count, 4'd5);
    step();
    chk("count_idle2", count, 4'd5);
    in = 8'h01; sample = 1'b1;
    step();
    sample = 1'b0;
    chk("count_next", count, 4'd1);
    drain();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
